serial_addsub_ctrl: RTL and testbench
=====================================

// Module: serial_addsub_ctrl
// PURPOSE
//   Bit-serial add/subtract sequencer. One shared 1-bit full_adder serves two
//   passes: first the operand add/subtract, then a two's-complement negate that
//   produces the result magnitude for the seven-segment display path.
//   Handshake is start/busy/done. Sits between the switch/operand inputs and
//   the segment decoder.
// PARAMETERS
//   WIDTH  4  operand/result width in bits, two's complement; legal range 2..8
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      request; accepted only in IDLE
//   op_sub     in   1      0: A+B, 1: A-B; sampled with start
//   a          in   WIDTH  operand A; sampled with start
//   b          in   WIDTH  operand B; sampled with start
//   busy       out  1      high in ADD and NEG states
//   done       out  1      one-cycle pulse in DONE state
//   result     out  WIDTH  signed sum/difference; held until next accepted start
//   negative   out  1      result[WIDTH-1]; held with result
//   overflow   out  1      signed overflow of the add pass; held with result
//   magnitude  out  WIDTH  |result| as unsigned; equals result when non-negative
// BEHAVIOUR
//   Reset (async): state=IDLE; busy=0, done=0, result=0, negative=0,
//     overflow=0, magnitude=0; bit index=0, carry=0.
//   FSM: IDLE -> ADD -> (NEG) -> DONE -> IDLE.
//   IDLE: start=1 at edge e0 latches a, b^{WIDTH{op_sub}}, op_sub; carry<=op_sub;
//     idx<=0; go to ADD. start=0 keeps IDLE.
//   ADD: each edge processes bit idx: sum = A[idx]^B'[idx]^carry, carry <= cout;
//     sum is shifted into the result register LSB-first. After WIDTH edges (eW):
//     overflow <= carry_into_msb ^ carry_out_of_msb; negative <= sum MSB.
//     If the MSB is 1, go to NEG; otherwise magnitude<=result and go to DONE.
//   NEG: the same adder computes ~result[idx] + 0 + carry, with carry preset to
//     1 on entry. Serial, WIDTH edges, writes magnitude. Then go to DONE.
//   DONE: done=1 for exactly one cycle; busy=0; return to IDLE next edge.
//   Latency from the start edge to done high: WIDTH cycles if result>=0,
//     2*WIDTH cycles if result<0.
//   start while busy or done is high: ignored. No queuing; a, b, op_sub changes
//     do not affect the operation in flight.
//   result/negative/overflow/magnitude are updated only when the pass that
//     writes them finishes. Between the start edge and that update they keep
//     the previous values, apart from the serial shift into internal
//     registers. The outputs are valid only while done=1 and after it.
//   Most-negative result (1000 for WIDTH=4): negation wraps, so magnitude=1000,
//     read as unsigned 8.
//   Overflow results are still negated by sign bit. The display shows the
//     wrapped value; overflow flags it.
//   Reset mid-operation: returns immediately to IDLE with all outputs zero. No
//     done pulse is generated.
// TESTING
//   a=0011 b=0010 op_sub=0 -> result=0101, negative=0, overflow=0,
//     magnitude=0101, done 4 cycles after start
//   a=0010 b=0101 op_sub=1 -> result=1101, negative=1, magnitude=0011,
//     done 8 cycles after start
//   a=0111 b=0001 op_sub=0 -> result=1000, overflow=1, negative=1,
//     magnitude=1000
//   a=1000 b=0001 op_sub=1 -> result=0111, overflow=1, negative=0,
//     magnitude=0111
//   start held high through ADD/NEG with new a/b -> one done pulse with the
//     first operands; second op only after IDLE
//   reset asserted at ADD bit 2 -> all outputs 0, state IDLE, no done; the next
//     start completes normally

Source files
------------

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer built around one shared 1-bit full adder.
// The adder runs an add/sub pass, then a negate pass when the result is negative.
module serial_addsub_fa (
    input  logic i_x,
    input  logic i_y,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y ^ i_c;
    assign o_c = (i_x & i_y) | (i_c & (i_x ^ i_y));
endmodule

module serial_addsub_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             overflow,
    output logic [WIDTH-1:0] magnitude
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_NEG,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_sh;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_neg;
    logic             r_ovf;
    logic [WIDTH-1:0] r_mag;

    logic             w_neg_pass;
    logic             w_last;
    logic             w_x;
    logic             w_y;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_shift;

    // NEG pass reuses the adder as ~result + carry-in of 1
    assign w_neg_pass = (r_state == S_NEG);
    assign w_last     = (r_idx == IW'(WIDTH - 1));
    assign w_x        = w_neg_pass ? ~r_result[r_idx] : r_a[r_idx];
    assign w_y        = w_neg_pass ? 1'b0 : r_b[r_idx];
    assign w_shift    = {w_s, r_sh[WIDTH-1:1]};

    serial_addsub_fa u_fa (
        .i_x(w_x),
        .i_y(w_y),
        .i_c(r_c),
        .o_s(w_s),
        .o_c(w_co)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_idx    <= '0;
            r_sh     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_mag    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{op_sub}};
                        r_c     <= op_sub;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_c   <= w_co;
                    r_sh  <= w_shift;
                    r_idx <= r_idx + IW'(1);
                    if (w_last) begin
                        r_result <= w_shift;
                        r_neg    <= w_s;
                        r_ovf    <= r_c ^ w_co;
                        r_idx    <= '0;
                        if (w_s) begin
                            r_c     <= 1'b1;
                            r_state <= S_NEG;
                        end else begin
                            r_mag   <= w_shift;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_NEG: begin
                    r_c   <= w_co;
                    r_sh  <= w_shift;
                    r_idx <= r_idx + IW'(1);
                    if (w_last) begin
                        r_mag   <= w_shift;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign negative  = r_neg;
    assign overflow  = r_ovf;
    assign magnitude = r_mag;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: directed vectors plus random operations
// checked against a signed-integer arithmetic reference model.
module tb_serial_addsub_ctrl;
    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         negative;
    logic         overflow;
    logic [W-1:0] magnitude;

    int total;
    int bad;

    logic [W-1:0] p_res;
    logic         p_neg;
    logic         p_ovf;
    logic [W-1:0] p_mag;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op_sub(op_sub),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result),
        .negative(negative),
        .overflow(overflow),
        .magnitude(magnitude)
    );

    always #5 clk = ~clk;

    function automatic int sval(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    function automatic void model(
        input  logic [W-1:0] fa,
        input  logic [W-1:0] fb,
        input  logic         fs,
        output logic [W-1:0] res,
        output logic         neg,
        output logic         ovf,
        output logic [W-1:0] mag,
        output int           lat
    );
        int t;
        int r;
        t   = fs ? sval(fa) - sval(fb) : sval(fa) + sval(fb);
        ovf = (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
        res = W'(t);
        r   = sval(res);
        neg = (r < 0);
        mag = W'(neg ? -r : r);
        lat = neg ? 2 * W : W;
    endfunction

    task automatic run_op(
        input logic [W-1:0] ta,
        input logic [W-1:0] tb,
        input logic         ts,
        input string        nm
    );
        logic [W-1:0] e_res;
        logic         e_neg;
        logic         e_ovf;
        logic [W-1:0] e_mag;
        int           e_lat;
        int           cnt;
        model(ta, tb, ts, e_res, e_neg, e_ovf, e_mag, e_lat);
        @(negedge clk);
        a = ta; b = tb; op_sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
        total++;
        if (busy !== 1'b1 || result !== p_res || magnitude !== p_mag) begin
            bad++;
            $display("FAIL %s hold: busy=%b res=%b mag=%b want busy=1 res=%b mag=%b",
                     nm, busy, result, magnitude, p_res, p_mag);
        end
        cnt = 0;
        while (cnt < 3 * W + 4) begin
            @(posedge clk); #1;
            cnt++;
            if (done === 1'b1) break;
        end
        total++;
        if (done !== 1'b1 || cnt != e_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d done=%b want %0d", nm, cnt, done, e_lat);
        end
        total++;
        if (result !== e_res || negative !== e_neg ||
            overflow !== e_ovf || magnitude !== e_mag || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s out: res=%b neg=%b ovf=%b mag=%b busy=%b want %b %b %b %b 0",
                     nm, result, negative, overflow, magnitude, busy,
                     e_res, e_neg, e_ovf, e_mag);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || result !== e_res || magnitude !== e_mag) begin
            bad++;
            $display("FAIL %s pulse: done=%b res=%b mag=%b want 0 %b %b",
                     nm, done, result, magnitude, e_res, e_mag);
        end
        p_res = e_res; p_neg = e_neg; p_ovf = e_ovf; p_mag = e_mag;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        total++;
        if (busy !== 0 || done !== 0 || result !== 0 ||
            negative !== 0 || overflow !== 0 || magnitude !== 0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b res=%b neg=%b ovf=%b mag=%b want all 0",
                     busy, done, result, negative, overflow, magnitude);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 0 || done !== 0 || result !== 0) begin
            bad++;
            $display("FAIL idle: busy=%b done=%b res=%b want 0 0 0", busy, done, result);
        end
        p_res = '0; p_neg = 0; p_ovf = 0; p_mag = '0;
    endtask

    task automatic test_vectors();
        run_op(4'b0011, 4'b0010, 1'b0, "vec_add");
        run_op(4'b0010, 4'b0101, 1'b1, "vec_subneg");
        run_op(4'b0111, 4'b0001, 1'b0, "vec_addovf");
        run_op(4'b1000, 4'b0001, 1'b1, "vec_subovf");
        run_op(4'b1000, 4'b0000, 1'b0, "vec_minneg");
        run_op(4'b0000, 4'b0000, 1'b1, "vec_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
    endtask

    task automatic test_back_to_back();
        run_op(4'b1111, 4'b1111, 1'b0, "b2b_0");
        run_op(4'b0101, 4'b0110, 1'b1, "b2b_1");
        run_op(4'b0110, 4'b0001, 1'b0, "b2b_2");
    endtask

    task automatic test_start_held();
        logic [W-1:0] e_res;
        logic         e_neg;
        logic         e_ovf;
        logic [W-1:0] e_mag;
        int           e_lat;
        int           cnt;
        int           pulses;
        model(4'b0010, 4'b0101, 1'b1, e_res, e_neg, e_ovf, e_mag, e_lat);
        @(negedge clk);
        a = 4'b0010; b = 4'b0101; op_sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        a = 4'b0001; b = 4'b0001; op_sub = 1'b0;
        cnt = 0;
        while (cnt < 3 * W + 4) begin
            @(posedge clk); #1;
            cnt++;
            if (done === 1'b1) break;
        end
        start = 1'b0;
        total++;
        if (done !== 1'b1 || cnt != e_lat || result !== e_res || magnitude !== e_mag) begin
            bad++;
            $display("FAIL held: cnt=%0d done=%b res=%b mag=%b want %0d 1 %b %b",
                     cnt, done, result, magnitude, e_lat, e_res, e_mag);
        end
        pulses = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0 || result !== e_res) begin
            bad++;
            $display("FAIL held_extra: activity=%0d res=%b want 0 %b", pulses, result, e_res);
        end
        p_res = e_res; p_neg = e_neg; p_ovf = e_ovf; p_mag = e_mag;
        run_op(4'b0001, 4'b0001, 1'b0, "held_next");
    endtask

    task automatic test_reset_mid();
        int pulses;
        run_op(4'b0010, 4'b0101, 1'b1, "pre_rst");
        @(negedge clk);
        a = 4'b0011; b = 4'b0100; op_sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 0 || done !== 0 || result !== 0 ||
            negative !== 0 || overflow !== 0 || magnitude !== 0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b res=%b neg=%b ovf=%b mag=%b want all 0",
                     busy, done, result, negative, overflow, magnitude);
        end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL mid_reset_quiet: activity=%0d want 0", pulses);
        end
        p_res = '0; p_neg = 0; p_ovf = 0; p_mag = '0;
        run_op(4'b0011, 4'b0100, 1'b1, "post_rst");
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; start = 1'b0; op_sub = 1'b0;
        a = '0; b = '0;
        total = 0; bad = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
